// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared types, constants and sizing helpers for the LCD SPI writer
// Purpose: sequencer state encoding, DC polarity constants, microsecond-to-cycle
// conversion and counter-width sizing used by lcd_spi_writer and its FIFO.
// Ports: none (package).

package lcd_spi_pkg;

    typedef enum logic [2:0] {
        RST_PULSE,
        RST_WAIT,
        IDLE,
        SHIFT,
        NEXT
    } lcd_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // A zero-length delay still costs one cycle, so the down-counters never
    // have to be loaded with a negative value.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned mhz);
        int unsigned cycles;
        cycles = us * mhz;
        return (cycles == 0) ? 1 : cycles;
    endfunction

    // Bits needed for a counter that runs from (count-1) down to 0, sized
    // for the larger of two counts.
    function automatic int counter_width(input int unsigned count_a, input int unsigned count_b);
        int unsigned biggest;
        biggest = (count_a > count_b) ? count_a : count_b;
        return (biggest < 2) ? 1 : $clog2(biggest);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous {DC, word} queue feeding the SPI shifter
// Purpose: power-of-two deep FIFO with registered level; read data is the head
// entry, valid whenever empty is low. A pushed entry becomes visible at the head
// only after the write edge, so there is no same-cycle fall-through.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (empties the queue)
//   push, push_data    write request and entry; ignored while full
//   pop, pop_data      read request and head entry; ignored while empty
//   level, full, empty occupancy status

import lcd_spi_pkg::*;

module lcd_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the pointers say
    // they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lcd_spi_writer.sv
// rtl/lcd_spi_writer.sv - ST7735-class panel reset sequencer and queued SPI word writer
// Purpose: drives the panel hardware-reset pulse and settle wait, then shifts
// queued {DC, word} entries out on a write-only SPI link (mode 0, MSB first).
// Back-to-back queued words share one CS-low window.
// Ports:
//   SYSTEM_CLK, SYSTEM_RST          clock, asynchronous active-high reset
//   WR_VALID, WR_READY, WR_DC,      queue push port (push when WR_VALID && WR_READY)
//   WR_DATA
//   START_RESET                     one-cycle request to re-run the panel reset sequence
//   INIT_DONE                       reset sequence complete, transfers permitted
//   BUSY                            sequencer not idle or queue not empty
//   FIFO_LEVEL                      queue occupancy
//   CS, MOSI, DC, LCD_CLK, RESET    panel pins (CS and RESET active low)

import lcd_spi_pkg::*;

module lcd_spi_writer #(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int SCLK_DIV        = 2,
    parameter int WORD_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int RESET_PULSE_US  = 10,
    parameter int RESET_WAIT_US   = 120000
) (
    input  logic                          SYSTEM_CLK,
    input  logic                          SYSTEM_RST,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic                          WR_DC,
    input  logic [WORD_WIDTH-1:0]         WR_DATA,
    input  logic                          START_RESET,
    output logic                          INIT_DONE,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          CS,
    output logic                          MOSI,
    output logic                          DC,
    output logic                          LCD_CLK,
    output logic                          RESET
);

    localparam int unsigned PULSE_CYCLES = us_to_cycles(RESET_PULSE_US, CLOCK_SPEED_MHZ);
    localparam int unsigned WAIT_CYCLES  = us_to_cycles(RESET_WAIT_US, CLOCK_SPEED_MHZ);
    localparam int          CNT_W        = counter_width(PULSE_CYCLES, WAIT_CYCLES);
    localparam int          DIV_W        = counter_width(SCLK_DIV, 1);
    localparam int          BIT_W        = counter_width(WORD_WIDTH, 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_WIDTH - 1);

    lcd_state_t              state;
    logic [CNT_W-1:0]        delay_cnt;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [WORD_WIDTH-1:0]   shift_reg;
    logic                    reset_pending;

    logic [WORD_WIDTH:0]     fifo_rd_data;
    logic [WORD_WIDTH-1:0]   fifo_word;
    logic                    fifo_dc;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    load_word;
    logic                    take_reset;

    assign {fifo_dc, fifo_word} = fifo_rd_data;

    lcd_cmd_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (SYSTEM_CLK),
        .rst       (SYSTEM_RST),
        .push      (WR_VALID),
        .push_data ({WR_DC, WR_DATA}),
        .pop       (load_word),
        .pop_data  (fifo_rd_data),
        .level     (FIFO_LEVEL),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A pending reset request is consumed only in states where no word is on
    // the wire; NEXT first drops CS and hands over to IDLE.
    always_comb begin
        take_reset = 1'b0;
        load_word  = 1'b0;
        if (reset_pending &&
            (state == RST_PULSE || state == RST_WAIT || state == IDLE)) begin
            take_reset = 1'b1;
        end
        if ((state == IDLE || state == NEXT) && !reset_pending && !fifo_empty) begin
            load_word = 1'b1;
        end
    end

    // BUSY and WR_READY decode registered state only.
    assign BUSY     = (state != IDLE) || !fifo_empty;
    assign WR_READY = !fifo_full;

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST) begin
            state         <= RST_PULSE;
            delay_cnt     <= PULSE_LOAD;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            reset_pending <= 1'b0;
            CS            <= 1'b1;
            MOSI          <= 1'b0;
            DC            <= DC_CMD;
            LCD_CLK       <= 1'b0;
            RESET         <= 1'b0;
            INIT_DONE     <= 1'b0;
        end else begin
            // A request arriving in the very cycle an older one is consumed
            // stays pending rather than being lost.
            reset_pending <= START_RESET || (reset_pending && !take_reset);

            case (state)
                RST_PULSE: begin
                    if (take_reset) begin
                        delay_cnt <= PULSE_LOAD;
                    end else if (delay_cnt == '0) begin
                        RESET     <= 1'b1;
                        delay_cnt <= WAIT_LOAD;
                        state     <= RST_WAIT;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end

                RST_WAIT: begin
                    if (take_reset) begin
                        RESET     <= 1'b0;
                        delay_cnt <= PULSE_LOAD;
                        state     <= RST_PULSE;
                    end else if (delay_cnt == '0) begin
                        INIT_DONE <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end

                IDLE: begin
                    CS      <= 1'b1;
                    LCD_CLK <= 1'b0;
                    if (take_reset) begin
                        INIT_DONE <= 1'b0;
                        RESET     <= 1'b0;
                        delay_cnt <= PULSE_LOAD;
                        state     <= RST_PULSE;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!LCD_CLK) begin
                            LCD_CLK <= 1'b1;
                        end else begin
                            LCD_CLK <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= NEXT;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                MOSI      <= shift_reg[WORD_WIDTH-1];
                                shift_reg <= shift_reg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                NEXT: begin
                    if (!load_word) begin
                        CS    <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= RST_PULSE;
                end
            endcase

            // Word load from IDLE or NEXT: LCD_CLK is already low here, so DC
            // and the first MOSI bit settle well before the first rising edge.
            if (load_word) begin
                CS        <= 1'b0;
                DC        <= fifo_dc;
                MOSI      <= fifo_word[WORD_WIDTH-1];
                shift_reg <= fifo_word << 1;
                bit_cnt   <= '0;
                div_cnt   <= '0;
                state     <= SHIFT;
            end
        end
    end

endmodule

// File: doc/lcd_spi_writer.md
Name: lcd_spi_writer

Overview:
Parametrised ST7735-class panel front end. Runs the panel hardware-reset sequence, then serialises queued command/data words onto a write-only SPI link (mode 0, MSB first).
Words enter through a valid/ready port into an internal FIFO of {DC, word} entries. Consecutive queued words go out back-to-back under one CS assertion.
Sits between the display controller logic and the panel pins, and supersedes the fixed single-register ST7735 writer.

Parameters:
CLOCK_SPEED_MHZ, 12, SYSTEM_CLK frequency in MHz; scales all microsecond delays.
SCLK_DIV, 2, SYSTEM_CLK cycles per LCD_CLK half period (>=1).
WORD_WIDTH, 8, bits per queued word; 8 for commands/params, 16 for RGB565 pixel streaming.
FIFO_DEPTH, 16, queue entries (power of 2, >=2).
RESET_PULSE_US, 10, duration RESET is held low.
RESET_WAIT_US, 120000, wait after RESET release before the first transfer.

Ports:
SYSTEM_CLK  in  1  system clock; all logic on rising edge.
SYSTEM_RST  in  1  asynchronous, active-high reset.
WR_VALID  in  1  queue push request.
WR_READY  out  1  queue not full; a push occurs when WR_VALID && WR_READY.
WR_DC  in  1  0 = command, 1 = data.
WR_DATA  in  WORD_WIDTH  word to send.
START_RESET  in  1  one-cycle request to re-run the panel reset sequence.
INIT_DONE  out  1  reset sequence complete; transfers permitted.
BUSY  out  1  state != IDLE or FIFO non-empty.
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current entry count.
CS  out  1  panel chip select, active low.
MOSI  out  1  serial data.
DC  out  1  panel data/command select.
LCD_CLK  out  1  SPI clock, idles low.
RESET  out  1  panel reset pin, active low.

Behaviour:
- SYSTEM_RST asserted (asynchronous): CS=1, MOSI=0, DC=0, LCD_CLK=0, RESET=0, INIT_DONE=0, FIFO emptied, START_RESET pending flag cleared, state=RST_PULSE, delay counter loaded. Applies immediately, including mid-word.
- RST_PULSE: RESET=0 for RESET_PULSE_US*CLOCK_SPEED_MHZ cycles. Then RESET<=1, load the wait count, go to RST_WAIT.
- RST_WAIT: count RESET_WAIT_US*CLOCK_SPEED_MHZ cycles, then INIT_DONE<=1 and go to IDLE. Size the counter for the larger of the two counts.
- FIFO: pushes are accepted in every state, including during reset, so the init sequence can be preloaded.
  - Push while full is impossible because WR_READY=0.
  - A push and a pop in the same cycle leave the level unchanged.
  - No fall-through: a word pushed into an empty FIFO is popped no earlier than the next cycle.
- IDLE: CS=1, LCD_CLK=0.
  - If a START_RESET is pending: clear INIT_DONE and go to RST_PULSE.
  - Else if the FIFO is non-empty: pop, CS<=0, DC<=entry DC, MOSI<=entry MSB, clear the bit counter, go to SHIFT.
- SHIFT: every SCLK_DIV cycles LCD_CLK toggles.
  - On each falling toggle (1->0) MOSI takes the next bit, MSB first.
  - After WORD_WIDTH rising edges and the following falling toggle, go to NEXT.
  - Each word occupies 2*SCLK_DIV*WORD_WIDTH cycles in SHIFT.
- NEXT (one cycle):
  - If a START_RESET is pending: CS<=1, go to IDLE, which handles the reset.
  - Else if the FIFO is non-empty: pop, update DC/MOSI while LCD_CLK=0, keep CS=0, go to SHIFT.
  - Else: CS<=1, go to IDLE.
- START_RESET is latched into the pending flag in any state. It never truncates a word in flight. Queued entries are retained and sent after the new sequence completes.
- START_RESET during RST_PULSE or RST_WAIT restarts the sequence from RST_PULSE.
- DC changes only while LCD_CLK=0, and no earlier than the cycle a word is loaded.
- All outputs are registered.

Decomposition:
- Package lcd_spi_pkg:
  - state encoding (RST_PULSE, RST_WAIT, IDLE, SHIFT, NEXT);
  - DC_CMD=0, DC_DATA=1;
  - function us_to_cycles(us, mhz);
  - function for counter width.
- Sub-module lcd_cmd_fifo: synchronous FIFO, width WORD_WIDTH+1, depth FIFO_DEPTH, asynchronous reset, with level, full and empty outputs.
- Top: sequencer plus shifter.

Test Plan:
Bench settings: CLOCK_SPEED_MHZ=12, RESET_PULSE_US=10, RESET_WAIT_US=5, SCLK_DIV=2.
- Release SYSTEM_RST -> RESET low for exactly 120 cycles, then high; INIT_DONE rises exactly 60 cycles later; CS stays 1 throughout.
- After INIT_DONE, push {DC=0, 8'h11} -> CS falls, DC=0, MOSI samples 0,0,0,1,0,0,0,1 on 8 LCD_CLK rising edges spaced 4 cycles apart; CS returns to 1; BUSY falls.
- Preload {0,8'h2A},{1,8'h00},{1,8'h7F} during reset -> after INIT_DONE, one CS-low window of 3 words; DC toggles 0->1 only while LCD_CLK=0 between words 1 and 2.
- Push 17 words with FIFO_DEPTH=16 and no drain (still in reset) -> WR_READY=0 at FIFO_LEVEL=16; 17th push not accepted; level stays 16.
- START_RESET pulsed mid-word with 2 words queued -> current word completes all 8 bits, CS=1, RESET low 120 cycles, INIT_DONE drops and then re-rises; the 2 queued words are then sent.
- SYSTEM_RST asserted at bit 3 of a word -> same cycle: CS=1, LCD_CLK=0, RESET=0, FIFO_LEVEL=0; WORD_WIDTH=16 run sends 16'hF800 MSB first in one CS window.
